del_fuse: RTL and testbench

DEL_FUSE -- requirements
Module: del_fuse

---
 rtl/del_fuse.sv | 140 ++++++++++++++
 tb/tb_del_fuse.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/del_fuse.sv
// del_fuse: selects old or new pixels per the HSSIM del word, with a stall-aware delay line aligning pixel beats to del.
// Optional frame statistics output frame_new_cnt is built only when DEL_FUSE_STATS_EN is defined.
module del_fuse #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DEL_LATENCY     = 8
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic                         stall,
    input  logic                         in_valid,
    input  logic [8*PIXELS_PER_BEAT-1:0] old_pix,
    input  logic [8*PIXELS_PER_BEAT-1:0] new_pix,
    input  logic [8*PIXELS_PER_BEAT-1:0] del,
    output logic [8*PIXELS_PER_BEAT-1:0] out_data,
    output logic                         out_valid,
    output logic                         out_last
`ifdef DEL_FUSE_STATS_EN
    ,
    output logic [$clog2(IMAGE_DIM*IMAGE_DIM+1)-1:0] frame_new_cnt
`endif
);

    localparam int W   = 8 * PIXELS_PER_BEAT;
    localparam int BPF = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CW  = (BPF > 1) ? $clog2(BPF) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BPF - 1);
    localparam logic [W-1:0]  SEL_MASK  = {PIXELS_PER_BEAT{8'h80}};

    logic [DEL_LATENCY-1:0] valid_pipe_r;
    logic [W-1:0]           old_pipe_r [DEL_LATENCY];
    logic [W-1:0]           new_pipe_r [DEL_LATENCY];
    logic [CW-1:0]          beat_cnt_r;
    logic                   tail_valid_s;
    logic                   is_last_s;
    logic [W-1:0]           fused_s;
    logic                   unused_del_s;

    function automatic logic [W-1:0] fuse_beat(input logic [W-1:0] o,
                                               input logic [W-1:0] n,
                                               input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            r[j*8 +: 8] = d[j*8+7] ? n[j*8 +: 8] : o[j*8 +: 8];
        end
        return r;
    endfunction

    // Valid bits of the delay line are reset so that flushed beats never emit.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            valid_pipe_r <= '0;
        end else if (!stall) begin
            valid_pipe_r[0] <= in_valid;
            for (int i = 1; i < DEL_LATENCY; i++) begin
                valid_pipe_r[i] <= valid_pipe_r[i-1];
            end
        end
    end

    // Pixel payload of the delay line; its contents are only meaningful under the valid bits.
    always_ff @(posedge clk) begin
        if (!stall) begin
            old_pipe_r[0] <= old_pix;
            new_pipe_r[0] <= new_pix;
            for (int i = 1; i < DEL_LATENCY; i++) begin
                old_pipe_r[i] <= old_pipe_r[i-1];
                new_pipe_r[i] <= new_pipe_r[i-1];
            end
        end
    end

    // Tail of the delay line meets del for the same beat in this cycle.
    always_comb begin
        tail_valid_s = valid_pipe_r[DEL_LATENCY-1];
        is_last_s    = (beat_cnt_r == LAST_BEAT);
        fused_s      = fuse_beat(old_pipe_r[DEL_LATENCY-1], new_pipe_r[DEL_LATENCY-1], del);
        unused_del_s = ^(del & ~SEL_MASK);
    end

    // Registered fused output and frame beat counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            beat_cnt_r <= '0;
        end else if (stall) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= tail_valid_s;
            if (tail_valid_s) begin
                out_data   <= fused_s;
                out_last   <= is_last_s;
                beat_cnt_r <= is_last_s ? '0 : beat_cnt_r + CW'(1);
            end else begin
                out_last <= 1'b0;
            end
        end
    end

`ifdef DEL_FUSE_STATS_EN
    localparam int NW  = $clog2(IMAGE_DIM * IMAGE_DIM + 1);
    localparam int PCW = $clog2(PIXELS_PER_BEAT + 1);

    logic [NW-1:0] running_r;
    logic [NW-1:0] beat_new_s;

    function automatic logic [PCW-1:0] count_new(input logic [W-1:0] d);
        logic [PCW-1:0] c;
        c = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            c = c + PCW'(d[j*8+7]);
        end
        return c;
    endfunction

    // Number of new pixels chosen in the beat currently at the tail.
    always_comb begin
        beat_new_s = NW'(count_new(del));
    end

    // Running per-frame new-pixel count, published on the last beat.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            running_r     <= '0;
            frame_new_cnt <= '0;
        end else if (!stall && tail_valid_s) begin
            if (is_last_s) begin
                frame_new_cnt <= running_r + beat_new_s;
                running_r     <= '0;
            end else begin
                running_r <= running_r + beat_new_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_del_fuse.sv
// Self-checking bench for del_fuse: directed scenarios plus random traffic against a beat-history reference model.
module tb_del_fuse;
    localparam int P   = 16;
    localparam int DIM = 8;
    localparam int DL  = 8;
    localparam int W   = 8 * P;
    localparam int BPF = DIM * DIM / P;
    localparam int HN  = 2048;

    logic         clk = 1'b0;
    logic         aresetn;
    logic         stall;
    logic         in_valid;
    logic [W-1:0] old_pix;
    logic [W-1:0] new_pix;
    logic [W-1:0] del;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
`ifdef DEL_FUSE_STATS_EN
    logic [6:0]   frame_new_cnt;
`endif

    del_fuse #(.PIXELS_PER_BEAT(P), .IMAGE_DIM(DIM), .DEL_LATENCY(DL)) dut (
        .clk(clk), .aresetn(aresetn), .stall(stall), .in_valid(in_valid),
        .old_pix(old_pix), .new_pix(new_pix), .del(del),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last)
`ifdef DEL_FUSE_STATS_EN
        , .frame_new_cnt(frame_new_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    // Model: beats indexed by advancing cycle; a beat from cycle a-DL emits at cycle a.
    int a = 0;
    int rst_base = 0;
    int beats = 0;
    int running = 0;
    int fnc = 0;
    logic         hv   [HN];
    logic [W-1:0] hold [HN];
    logic [W-1:0] hnew [HN];
    logic [W-1:0] hdel [HN];
    logic [W-1:0] exp_data = '0;
    logic         exp_v = 1'b0;
    logic         exp_last = 1'b0;

    function automatic logic [W-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [W-1:0] rep(input logic [7:0] b);
        return {P{b}};
    endfunction

    function automatic logic [W-1:0] alt2(input logic [7:0] even_b, input logic [7:0] odd_b);
        logic [W-1:0] r;
        for (int j = 0; j < P; j++) r[j*8 +: 8] = (j % 2 == 0) ? even_b : odd_b;
        return r;
    endfunction

    function automatic logic [W-1:0] ref_fuse(input logic [W-1:0] o, input logic [W-1:0] n,
                                              input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int j = 0; j < P; j++) r[j*8 +: 8] = (d[j*8 +: 8] >= 8'd128) ? n[j*8 +: 8] : o[j*8 +: 8];
        return r;
    endfunction

    function automatic int ref_new(input logic [W-1:0] d);
        int c = 0;
        for (int j = 0; j < P; j++) if (d[j*8 +: 8] >= 8'd128) c++;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] o, input logic [W-1:0] n,
                        input logic [W-1:0] d, input logic st);
        int src;
        int k;
        in_valid = v;
        old_pix  = o;
        new_pix  = n;
        stall    = st;
        del      = (a >= DL) ? hdel[a-DL] : rand_word();
        if (!st) begin
            hv[a] = v; hold[a] = o; hnew[a] = n; hdel[a] = d;
        end
        @(posedge clk);
        #1;
        if (st) begin
            exp_v = 1'b0;
        end else begin
            src   = a - DL;
            exp_v = (src >= rst_base) && hv[src];
            if (exp_v) begin
                exp_data = ref_fuse(hold[src], hnew[src], hdel[src]);
                exp_last = ((beats % BPF) == BPF - 1);
                beats++;
                k = ref_new(hdel[src]);
                if (exp_last) begin
                    fnc = running + k;
                    running = 0;
                end else begin
                    running += k;
                end
            end
            a++;
        end
        chk("out_valid", W'(out_valid), W'(exp_v));
        chk("out_data", out_data, exp_data);
        if (exp_v) chk("out_last", W'(out_last), W'(exp_last));
`ifdef DEL_FUSE_STATS_EN
        chk("frame_new_cnt", W'(frame_new_cnt), W'(fnc));
`endif
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, rand_word(), rand_word(), rand_word(), 1'b0);
    endtask

    task automatic do_reset();
        aresetn  = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        #1;
        rst_base = a; beats = 0; running = 0; fnc = 0;
        exp_data = '0;
        chk("rst_out_valid", W'(out_valid), W'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", W'(out_last), W'(1'b0));
`ifdef DEL_FUSE_STATS_EN
        chk("rst_frame_new_cnt", W'(frame_new_cnt), '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
    endtask

    // One beat of 0x11 old / 0xEE new; latency and per-pixel selection checked against constants.
    task automatic single_beat(input string tag, input logic [W-1:0] d);
        step(1'b1, rep(8'h11), rep(8'hEE), d, 1'b0);
        drain(7);
        drain(1);
        chk({tag, "_valid"}, W'(out_valid), W'(1'b1));
        chk({tag, "_data"}, out_data, alt2(8'hEE, 8'h11));
    endtask

    initial begin
        aresetn = 1'b1; stall = 1'b0; in_valid = 1'b0;
        old_pix = '0; new_pix = '0; del = '0;
        #2;
        do_reset();

        single_beat("single_ff00", alt2(8'hFF, 8'h00));
        single_beat("single_807f", alt2(8'h80, 8'h7F));

        // Full frame with del all zero: old pixels throughout, last on the 4th strobe.
        do_reset();
        repeat (4) step(1'b1, rand_word(), rand_word(), rep(8'h00), 1'b0);
        drain(DL + 1);

        // Full frame with a 3-cycle stall mid-stream on the input side.
        do_reset();
        repeat (2) step(1'b1, rand_word(), rand_word(), rep(8'h00), 1'b0);
        repeat (3) step(1'b1, rand_word(), rand_word(), rand_word(), 1'b1);
        repeat (2) step(1'b1, rand_word(), rand_word(), rep(8'h00), 1'b0);
        drain(DL + 1);

        // Stall exactly on the edge where the last beat would emit.
        do_reset();
        repeat (4) step(1'b1, rand_word(), rand_word(), rand_word(), 1'b0);
        drain(DL - 1);
        repeat (2) step(1'b0, rand_word(), rand_word(), rand_word(), 1'b1);
        drain(4);

        // Reset mid-frame flushes in-flight beats; the next frame starts at beat 0.
        do_reset();
        repeat (2) step(1'b1, rand_word(), rand_word(), rand_word(), 1'b0);
        drain(3);
        do_reset();
        repeat (4) step(1'b1, rand_word(), rand_word(), rand_word(), 1'b0);
        drain(DL + 1);

        // Two frames: all new, then half new.
        do_reset();
        repeat (4) step(1'b1, rand_word(), rand_word(), rep(8'hFF), 1'b0);
        drain(DL + 1);
`ifdef DEL_FUSE_STATS_EN
        chk("frame1_new_cnt", W'(frame_new_cnt), W'(64));
`endif
        repeat (4) step(1'b1, rand_word(), rand_word(), alt2(8'hFF, 8'h00), 1'b0);
        drain(DL + 1);
`ifdef DEL_FUSE_STATS_EN
        chk("frame2_new_cnt", W'(frame_new_cnt), W'(32));
`endif

        // Random traffic with bubbles, stalls and mixed del bytes.
        do_reset();
        repeat (300) begin
            logic [W-1:0] d;
            for (int j = 0; j < P; j++) begin
                case ($urandom_range(0, 4))
                    0: d[j*8 +: 8] = 8'hFF;
                    1: d[j*8 +: 8] = 8'h00;
                    2: d[j*8 +: 8] = 8'h80;
                    3: d[j*8 +: 8] = 8'h7F;
                    default: d[j*8 +: 8] = 8'($urandom());
                endcase
            end
            step($urandom_range(0, 9) < 7, rand_word(), rand_word(), d, $urandom_range(0, 9) < 2);
        end
        drain(DL + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
